// File: rtl/knn_pkg.sv
// Shared types and sizing helpers for the KNN distance engine.
package knn_pkg;

  typedef enum logic [2:0] {IDLE, ACCUM, DECIDE, INSERT, VOTE, OUT} state_e;

  function automatic int chunk_f(input int max_el, input int mn);
    return (max_el < mn) ? max_el : mn;
  endfunction

  // Wide enough for M*N maximal squared differences.
  function automatic int dist_w_f(input int w, input int mn);
    return 2 * w + $clog2(mn) + 1;
  endfunction

endpackage

// File: rtl/knn_topk_list.sv
// Ascending K-entry (distance, type) list with single-cycle parallel
// compare-and-shift insertion; equal distances land after existing entries.
module knn_topk_list #(
  parameter int K      = 3,
  parameter int DIST_W = 19,
  parameter int TYPE_W = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ins_i,
  input  logic                        clr_i,
  input  logic [DIST_W-1:0]           dist_i,
  input  logic [TYPE_W-1:0]           type_i,
  output logic [K-1:0][DIST_W-1:0]    dist_o,
  output logic [K-1:0][TYPE_W-1:0]    type_o,
  output logic [K-1:0]                vld_o
);

  // lt[g]: new entry belongs at or before slot g; monotonic since valid
  // entries are packed at the front in ascending order.
  logic [K-1:0] lt;

  for (genvar g = 0; g < K; g++) begin : g_ent
    logic [DIST_W-1:0] d_q, pd;
    logic [TYPE_W-1:0] t_q, pt;
    logic              v_q, pv;
    logic              take_new, take_prev;

    assign lt[g]     = !v_q || (dist_i < d_q);
    assign dist_o[g] = d_q;
    assign type_o[g] = t_q;
    assign vld_o[g]  = v_q;

    if (g == 0) begin : g_head
      assign take_new  = lt[0];
      assign take_prev = 1'b0;
      assign pd = '0;
      assign pt = '0;
      assign pv = 1'b0;
    end else begin : g_tail
      assign take_new  = lt[g] && !lt[g-1];
      assign take_prev = lt[g] && lt[g-1];
      assign pd = dist_o[g-1];
      assign pt = type_o[g-1];
      assign pv = vld_o[g-1];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        d_q <= '0;
        t_q <= '0;
        v_q <= 1'b0;
      end else if (clr_i) begin
        v_q <= 1'b0;
      end else if (ins_i) begin
        if (take_new) begin
          d_q <= dist_i;
          t_q <= type_i;
          v_q <= 1'b1;
        end else if (take_prev) begin
          d_q <= pd;
          t_q <= pt;
          v_q <= pv;
        end
      end
    end
  end

endmodule

// File: rtl/knn_distance_engine.sv
// KNN distance engine: streams chunks into a squared-distance accumulator,
// keeps the K nearest samples and votes a class every L samples.
module knn_distance_engine import knn_pkg::*; #(
  parameter int M            = 2,
  parameter int N            = 2,
  parameter int W            = 8,
  parameter int MAX_ELEMENTS = 4,
  parameter int TYPE_W       = 2,
  parameter int L            = 3,
  parameter int K            = 3,
  parameter int DIST_W       = dist_w_f(W, M * N)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       read_done,
  input  logic [M*N-1:0][W-1:0]      input_data,
  input  logic [M*N-1:0][W-1:0]      training_data,
  input  logic [TYPE_W-1:0]          training_data_type,
  output logic                       data_request,
  output logic                       done,
  output logic [TYPE_W-1:0]          inferred_type,
  output logic                       inference_done
);

  localparam int MN    = M * N;
  localparam int CHUNK = chunk_f(MAX_ELEMENTS, MN);
  localparam int EW    = (MN > 1) ? $clog2(MN) : 1;
  localparam int CW    = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  localparam int SW    = $clog2(L + 1);
  localparam int CNTW  = $clog2(K + 1);

  state_e                    state_q;
  logic [CHUNK-1:0][W-1:0]   a_q, b_q;
  logic [TYPE_W-1:0]         type_q, vt_q, best_q, inferred_type_q;
  logic [CW-1:0]             ci_q;
  logic [EW-1:0]             elem_q;
  logic [SW-1:0]             smp_q;
  logic [DIST_W-1:0]         acc_q, acc_d;
  logic [CNTW-1:0]           best_cnt_q, vote_cnt;
  logic                      data_request_q, done_q, inference_done_q;

  logic [W-1:0]              ea, eb, diff;
  logic [2*W-1:0]            sq;
  logic [K-1:0][DIST_W-1:0]  l_dist;
  logic [K-1:0][TYPE_W-1:0]  l_type;
  logic [K-1:0]              l_vld;

  assign ea    = a_q[ci_q];
  assign eb    = b_q[ci_q];
  assign diff  = (ea >= eb) ? ea - eb : eb - ea;
  assign sq    = diff * diff;
  assign acc_d = acc_q + DIST_W'(sq);

  always_comb begin
    vote_cnt = '0;
    for (int i = 0; i < K; i++)
      if (l_vld[i] && l_type[i] == vt_q) vote_cnt = vote_cnt + 1'b1;
  end

  knn_topk_list #(.K(K), .DIST_W(DIST_W), .TYPE_W(TYPE_W)) u_list (
    .clk    (clk),
    .rst    (rst),
    .ins_i  (state_q == INSERT),
    .clr_i  (state_q == OUT),
    .dist_i (acc_q),
    .type_i (type_q),
    .dist_o (l_dist),
    .type_o (l_type),
    .vld_o  (l_vld)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      a_q              <= '0;
      b_q              <= '0;
      type_q           <= '0;
      ci_q             <= '0;
      elem_q           <= '0;
      smp_q            <= '0;
      acc_q            <= '0;
      vt_q             <= '0;
      best_q           <= '0;
      best_cnt_q       <= '0;
      inferred_type_q  <= '0;
      data_request_q   <= 1'b0;
      done_q           <= 1'b0;
      inference_done_q <= 1'b0;
    end else begin
      data_request_q   <= 1'b0;
      done_q           <= 1'b0;
      inference_done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (read_done) begin
          for (int i = 0; i < CHUNK; i++) begin
            a_q[i] <= input_data[i];
            b_q[i] <= training_data[i];
          end
          type_q  <= training_data_type;
          ci_q    <= '0;
          state_q <= ACCUM;
        end
        ACCUM: begin
          acc_q  <= acc_d;
          elem_q <= (elem_q == EW'(MN - 1)) ? '0 : elem_q + 1'b1;
          ci_q   <= ci_q + 1'b1;
          if (ci_q == CW'(CHUNK - 1)) state_q <= DECIDE;
        end
        DECIDE: begin
          // Partial sample: acc is kept across the request for the next chunk.
          if (elem_q != '0) begin
            data_request_q <= 1'b1;
            state_q        <= IDLE;
          end else begin
            state_q <= INSERT;
          end
        end
        INSERT: begin
          done_q <= 1'b1;
          acc_q  <= '0;
          smp_q  <= smp_q + 1'b1;
          if (smp_q == SW'(L - 1)) begin
            vt_q       <= '0;
            best_q     <= '0;
            best_cnt_q <= '0;
            state_q    <= VOTE;
          end else begin
            state_q <= IDLE;
          end
        end
        VOTE: begin
          // Strictly-greater replacement resolves ties to the lowest type.
          if (vote_cnt > best_cnt_q) begin
            best_cnt_q <= vote_cnt;
            best_q     <= vt_q;
          end
          vt_q <= vt_q + 1'b1;
          if (vt_q == '1) state_q <= OUT;
        end
        OUT: begin
          inferred_type_q  <= best_q;
          inference_done_q <= 1'b1;
          smp_q            <= '0;
          state_q          <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_request   = data_request_q;
  assign done           = done_q;
  assign inferred_type  = inferred_type_q;
  assign inference_done = inference_done_q;

endmodule

// File: tb/tb_knn_distance_engine.sv
// Directed bench: u_main uses the default configuration, u_alt uses
// MAX_ELEMENTS=2, K=2 for chunking and list-overflow scenarios.
module tb_knn_distance_engine;

  logic             clk, rst, rd_a, rd_b;
  logic [3:0][7:0]  in_d, tr_d;
  logic [1:0]       ty;
  logic             dr_a, done_a, inf_a, dr_b, done_b, inf_b;
  logic [1:0]       it_a, it_b;
  int               n_cmp, n_bad;

  knn_distance_engine u_main (
    .clk(clk), .rst(rst), .read_done(rd_a), .input_data(in_d),
    .training_data(tr_d), .training_data_type(ty), .data_request(dr_a),
    .done(done_a), .inferred_type(it_a), .inference_done(inf_a)
  );

  knn_distance_engine #(.MAX_ELEMENTS(2), .K(2)) u_alt (
    .clk(clk), .rst(rst), .read_done(rd_b), .input_data(in_d),
    .training_data(tr_d), .training_data_type(ty), .data_request(dr_b),
    .done(done_b), .inferred_type(it_b), .inference_done(inf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses read_done on one DUT and records (in cycles after the read_done
  // cycle) the first done, data_request and inference_done seen within 30.
  task automatic run_sample(input bit alt, input logic [3:0][7:0] a,
                            input logic [3:0][7:0] b, input logic [1:0] t,
                            input int spur, output int done_at,
                            output int dr_at, output int inf_at,
                            output int both);
    logic d, r, f;
    done_at = -1; dr_at = -1; inf_at = -1; both = 0;
    @(negedge clk);
    in_d = a; tr_d = b; ty = t;
    if (alt) rd_b = 1'b1; else rd_a = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      rd_a = 1'b0; rd_b = 1'b0;
      if (k == spur) begin
        in_d = '1; tr_d = '0; ty = 2'd0;
        if (alt) rd_b = 1'b1; else rd_a = 1'b1;
      end
      d = alt ? done_b : done_a;
      r = alt ? dr_b : dr_a;
      f = alt ? inf_b : inf_a;
      if (d && done_at < 0) done_at = k;
      if (r && dr_at < 0) dr_at = k;
      if (f && inf_at < 0) inf_at = k;
      if ((d && r) || (d && f)) both++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; rd_a = 1'b0; rd_b = 1'b0; in_d = '0; tr_d = '0; ty = '0;
    #2;
    n_cmp++;
    if ({dr_a, done_a, inf_a, it_a} !== 5'd0) begin
      n_bad++; $display("FAIL reset_main: got %b expected 00000", {dr_a, done_a, inf_a, it_a});
    end
    n_cmp++;
    if ({dr_b, done_b, inf_b, it_b} !== 5'd0) begin
      n_bad++; $display("FAIL reset_alt: got %b expected 00000", {dr_b, done_b, inf_b, it_b});
    end
    n_cmp++;
    if ({u_main.u_list.vld_o, u_alt.u_list.vld_o} !== 5'd0) begin
      n_bad++; $display("FAIL reset_vld: got %b expected 00000", {u_main.u_list.vld_o, u_alt.u_list.vld_o});
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_identical();
    int dn, dr, inf, both;
    run_sample(0, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd4, 8'd3, 8'd2, 8'd1}, 2'd2, 0, dn, dr, inf, both);
    n_cmp++;
    if (dn !== 7) begin n_bad++; $display("FAIL ident_done_lat: got %0d expected 7", dn); end
    n_cmp++;
    if (dr !== -1) begin n_bad++; $display("FAIL ident_no_req: got %0d expected -1", dr); end
    n_cmp++;
    if (u_main.u_list.dist_o[0] !== 19'd0 || u_main.u_list.type_o[0] !== 2'd2 || u_main.u_list.vld_o !== 3'b001) begin
      n_bad++; $display("FAIL ident_list: got d=%0d t=%0d v=%b expected d=0 t=2 v=001",
                        u_main.u_list.dist_o[0], u_main.u_list.type_o[0], u_main.u_list.vld_o);
    end
  endtask

  task automatic test_chunking();
    int dn, dr, inf, both;
    run_sample(1, '0, {8'd0, 8'd0, 8'd4, 8'd3}, 2'd1, 0, dn, dr, inf, both);
    n_cmp++;
    if (dr !== 4 || dn !== -1) begin
      n_bad++; $display("FAIL chunk1: got req=%0d done=%0d expected req=4 done=-1", dr, dn);
    end
    run_sample(1, '0, {8'd0, 8'd0, 8'd255, 8'd255}, 2'd1, 0, dn, dr, inf, both);
    n_cmp++;
    if (dn !== 5 || dr !== -1) begin
      n_bad++; $display("FAIL chunk2: got done=%0d req=%0d expected done=5 req=-1", dn, dr);
    end
    n_cmp++;
    if (u_alt.u_list.dist_o[0] !== 19'd130075 || u_alt.u_list.vld_o !== 2'b01) begin
      n_bad++; $display("FAIL chunk_dist: got %0d v=%b expected 130075 v=01",
                        u_alt.u_list.dist_o[0], u_alt.u_list.vld_o);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    @(negedge clk);
    in_d = {8'd4, 8'd3, 8'd2, 8'd1}; tr_d = '0; ty = 2'd3; rd_a = 1'b1;
    @(negedge clk); rd_a = 1'b0;
    @(negedge clk); rst = 1'b0;
    #1;
    n_cmp++;
    if ({dr_a, done_a, inf_a, it_a} !== 5'd0 || u_main.u_list.vld_o !== 3'b000 || u_alt.u_list.vld_o !== 2'b00) begin
      n_bad++; $display("FAIL midreset_outs: got %b vld=%b/%b expected all zero",
                        {dr_a, done_a, inf_a, it_a}, u_main.u_list.vld_o, u_alt.u_list.vld_o);
    end
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done_a || dr_a) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL midreset_quiet: got %0d pulses expected 0", seen); end
  endtask

  task automatic test_vote();
    int dn[3], dr[3], inf[3], both[3];
    run_sample(0, '0, {8'd1, 8'd1, 8'd1, 8'd1}, 2'd1, 0, dn[0], dr[0], inf[0], both[0]);
    run_sample(0, '0, {8'd0, 8'd0, 8'd0, 8'd9}, 2'd3, 0, dn[1], dr[1], inf[1], both[1]);
    run_sample(0, '0, {8'd0, 8'd0, 8'd0, 8'd2}, 2'd1, 0, dn[2], dr[2], inf[2], both[2]);
    n_cmp++;
    if (dn[0] !== 7 || dn[1] !== 7 || dn[2] !== 7) begin
      n_bad++; $display("FAIL vote_done_lat: got %0d/%0d/%0d expected 7/7/7", dn[0], dn[1], dn[2]);
    end
    n_cmp++;
    if (inf[0] !== -1 || inf[1] !== -1 || inf[2] !== 12) begin
      n_bad++; $display("FAIL vote_inf_lat: got %0d/%0d/%0d expected -1/-1/12", inf[0], inf[1], inf[2]);
    end
    n_cmp++;
    if (it_a !== 2'd1) begin n_bad++; $display("FAIL vote_type: got %0d expected 1", it_a); end
    n_cmp++;
    if (u_main.u_list.type_o !== {2'd3, 2'd1, 2'd1} || u_main.u_list.dist_o[0] !== 19'd4 ||
        u_main.u_list.dist_o[1] !== 19'd4 || u_main.u_list.dist_o[2] !== 19'd81) begin
      n_bad++; $display("FAIL vote_order: got types %b d=%0d,%0d,%0d expected 110101 d=4,4,81",
                        u_main.u_list.type_o, u_main.u_list.dist_o[0], u_main.u_list.dist_o[1], u_main.u_list.dist_o[2]);
    end
    n_cmp++;
    if (u_main.u_list.vld_o !== 3'b000 || (both[0] + both[1] + both[2]) !== 0) begin
      n_bad++; $display("FAIL vote_clear: got vld=%b overlaps=%0d expected 000/0",
                        u_main.u_list.vld_o, both[0] + both[1] + both[2]);
    end
  endtask

  task automatic test_tie();
    int dn, dr, inf, both;
    int infs[3];
    logic [3:0][7:0] v[3];
    logic [1:0] t[3];
    v[0] = {8'd0, 8'd0, 8'd3, 8'd1}; t[0] = 2'd2;
    v[1] = {8'd0, 8'd0, 8'd2, 8'd1}; t[1] = 2'd0;
    v[2] = {8'd0, 8'd0, 8'd4, 8'd2}; t[2] = 2'd3;
    for (int s = 0; s < 3; s++) begin
      run_sample(1, v[s], '0, t[s], 0, dn, dr, inf, both);
      run_sample(1, '0, '0, t[s], 0, dn, dr, infs[s], both);
    end
    n_cmp++;
    if (infs[0] !== -1 || infs[1] !== -1 || infs[2] !== 10) begin
      n_bad++; $display("FAIL tie_inf_lat: got %0d/%0d/%0d expected -1/-1/10", infs[0], infs[1], infs[2]);
    end
    n_cmp++;
    if (it_b !== 2'd0) begin n_bad++; $display("FAIL tie_type: got %0d expected 0", it_b); end
    n_cmp++;
    if (u_alt.u_list.dist_o[0] !== 19'd5 || u_alt.u_list.dist_o[1] !== 19'd10 ||
        u_alt.u_list.type_o !== {2'd2, 2'd0}) begin
      n_bad++; $display("FAIL tie_list: got d=%0d,%0d types %b expected d=5,10 types 1000",
                        u_alt.u_list.dist_o[0], u_alt.u_list.dist_o[1], u_alt.u_list.type_o);
    end
  endtask

  task automatic test_spurious();
    int dn, dr, inf, both;
    run_sample(0, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd5, 8'd5, 8'd5, 8'd5}, 2'd3, 2, dn, dr, inf, both);
    n_cmp++;
    if (dn !== 7 || dr !== -1 || inf !== -1) begin
      n_bad++; $display("FAIL spur_timing: got done=%0d req=%0d inf=%0d expected 7/-1/-1", dn, dr, inf);
    end
    n_cmp++;
    if (u_main.u_list.dist_o[0] !== 19'd30 || u_main.u_list.type_o[0] !== 2'd3 || u_main.u_list.vld_o !== 3'b001) begin
      n_bad++; $display("FAIL spur_list: got d=%0d t=%0d v=%b expected d=30 t=3 v=001",
                        u_main.u_list.dist_o[0], u_main.u_list.type_o[0], u_main.u_list.vld_o);
    end
    n_cmp++;
    if (it_a !== 2'd1) begin n_bad++; $display("FAIL spur_type_held: got %0d expected 1", it_a); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    test_reset();
    test_identical();
    test_chunking();
    test_reset_mid();
    test_vote();
    test_tie();
    test_spurious();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/knn_distance_engine.md
Name: knn_distance_engine

Overview:
- Downstream consumer of the memory control stage of the KNN system.
- Takes each input/training chunk on read_done and accumulates the squared Euclidean distance one element per cycle.
- Requests further chunks with data_request and reports each completed training sample with done, while keeping a sorted list of the K nearest samples.
- After L samples, takes a majority vote and returns inferred_type with an inference_done pulse for write-back.

Parameters:
- M, 2: image rows.
- N, 2: image columns.
- W, 8: element/word width (unsigned).
- MAX_ELEMENTS, 4: chunk size delivered per read_done. CHUNK = min(MAX_ELEMENTS, M*N). M*N must be a multiple of CHUNK.
- TYPE_W, 2: class label width.
- L, 3: training samples per inference.
- K, 3: neighbours kept, 1 <= K.
- DIST_W, 2*W+$clog2(M*N)+1: distance accumulator width; never overflows.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- read_done  in  1  one-cycle pulse; chunk arrays and type are valid this cycle.
- input_data  in  W x (M*N)  input chunk; elements 0..CHUNK-1 used.
- training_data  in  W x (M*N)  training chunk; elements 0..CHUNK-1 used.
- training_data_type  in  TYPE_W  label of the current training sample.
- data_request  out  1  one-cycle pulse: chunk consumed, sample incomplete, send next chunk.
- done  out  1  one-cycle pulse: training sample distance complete and inserted.
- inferred_type  out  TYPE_W  voted class; held until next inference_done.
- inference_done  out  1  one-cycle pulse; inferred_type valid this cycle.

Behaviour:
- Reset (rst low, async): all outputs 0. State IDLE. acc=0, elem_cnt=0, sample_cnt=0, all list valid bits 0.
- IDLE: on read_done=1, capture CHUNK elements of both arrays plus training_data_type into internal registers, then go to ACCUM. read_done seen in any other state is ignored; the protocol forbids it.
- ACCUM: one element per cycle, acc += (a-b)^2, with |a-b| computed unsigned in W bits. Takes exactly CHUNK cycles. elem_cnt counts elements of the sample and wraps at M*N.
- DECIDE: if elem_cnt != 0, pulse data_request and return to IDLE with acc held. Otherwise go to INSERT.
- Latency: the data_request or done pulse is high in the cycle CHUNK+2 clocks after the read_done sampling edge. For done this includes the INSERT cycle, so done latency is CHUNK+3.
- INSERT, single cycle:
  - (acc, type) is inserted into an ascending list of K entries.
  - On equal distance, the new entry goes after existing entries.
  - If the list is full and acc is >= the last entry, the list is unchanged.
  - Then: done pulse, acc=0, sample_cnt++.
  - If sample_cnt reaches L, go to VOTE; otherwise go to IDLE.
- VOTE:
  - Walk types 0 .. 2^TYPE_W-1, one per cycle.
  - Count the valid entries holding that type; keep the best count, replacing it only on a strictly greater count, so ties resolve to the lowest type.
  - Then go to OUT.
- OUT:
  - inferred_type <= best and inference_done pulses for one cycle.
  - Clear list valid bits, sample_cnt=0, go to IDLE.
  - If no valid entries exist (cannot happen with L >= 1), best is 0.
- Mid-operation reset aborts everything. The next read_done starts a fresh sample and a fresh inference.
- data_request and done are never high in the same cycle. inference_done is never coincident with done; it follows it by at least 2^TYPE_W+1 cycles.

Decomposition:
- Package knn_pkg holds:
  - state enum {IDLE, ACCUM, DECIDE, INSERT, VOTE, OUT};
  - CHUNK as min(MAX_ELEMENTS, M*N);
  - the DIST_W helper function.
- Sub-module knn_topk_list, parameters K, DIST_W, TYPE_W:
  - ports: insert strobe, distance, type, clear;
  - exposes the entry/valid arrays;
  - single-cycle parallel compare-and-shift insertion.

Test Plan:
- Common configuration: M=N=2, W=8, MAX_ELEMENTS=4, TYPE_W=2, L=3, K=3 unless stated.
- Identical chunk: input [1,2,3,4], training [1,2,3,4] type 2 -> acc=0; done pulses CHUNK+3=7 cycles after read_done; no data_request.
- Chunking (MAX_ELEMENTS=2): first chunk [0,0] vs [3,4] -> data_request only. Second chunk [0,0] vs [255,255] -> done, stored distance 25+130050=130075.
- Vote:
  - Samples are all input [0,0,0,0].
  - Training: [1,1,1,1] type 1 (d=4), [9,0,0,0] type 3 (d=81), [2,0,0,0] type 1 (d=4).
  - Expected: list order type1, type1 (stable), type3; inferred_type=1; inference_done 5 cycles after the third done.
- Tie and list overflow (K=2, L=3):
  - Distances 10 (type 2), 5 (type 0), 20 (type 3).
  - The third sample is dropped.
  - Votes tie 1:1 -> inferred_type=0.
- Reset mid-ACCUM: rst low for 1 cycle, 2 cycles after read_done -> no done; outputs 0. The next full sequence gives correct results with sample_cnt restarting at 0.
- Spurious read_done during ACCUM -> ignored; acc and the done timing are unchanged.
